credit_rx_buffer: RTL and testbench

//   Receive end of the PE-to-router credit link. Accepts 20-bit flits qualified
//   by in_valid into a DEPTH-entry FIFO and presents them in order on a

---
 rtl/credit_rx_buffer.sv | 115 +++++++++++
 tb/tb_credit_rx_buffer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/credit_rx_buffer.sv
// rtl/credit_rx_buffer.sv - receive-side credit FIFO for the PE-to-router credit link
//
// Purpose:
//   Accepts WIDTH-bit flits qualified by in_valid into a DEPTH-entry FIFO and
//   presents them in order on a valid/ready output. Each entry that leaves the
//   FIFO returns one credit pulse on co, one cycle after the pop, so the
//   sender's allocation counter (reset 0, limit DEPTH) stays exact.
//
// Optional feature macro: CREDIT_CHECK_EN
//   defined   - err_ovf is a sticky flag, set the cycle after in_valid arrives
//               while the FIFO is full; cleared only by RST.
//   undefined - err_ovf is tied to 0 and no checking logic exists.
//   In both builds a flit offered while full is dropped.
//
// Ports:
//   clk        in   1      clock, rising edge
//   RST        in   1      asynchronous active-low reset
//   datain     in   WIDTH  incoming flit
//   in_valid   in   1      push request for datain
//   co         out  1      credit return, one pulse per popped entry
//   dataout    out  WIDTH  FIFO head flit (don't-care while out_valid=0)
//   out_valid  out  1      FIFO not empty
//   out_ready  in   1      downstream accepts dataout this cycle
//   occupancy  out  AW+1   entries held, 0..DEPTH
//   err_ovf    out  1      sticky overflow flag

module credit_rx_buffer #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [WIDTH-1:0] datain,
    input  logic             in_valid,
    output logic             co,
    output logic [WIDTH-1:0] dataout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW:0]      occupancy,
    output logic             err_ovf
);

    // Storage is deliberately not reset: held flits are discarded by resetting
    // the pointers, and dataout is don't-care while the FIFO is empty.
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without a separate count register.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             r_co;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_occupancy;

    assign w_occupancy = r_wr_ptr - r_rd_ptr;
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A push while full is refused even if a pop happens in the same cycle:
    // a credit-correct sender can never be in that situation.
    assign w_push = in_valid & ~w_full;
    assign w_pop  = ~w_empty & out_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= datain;
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_co     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // One credit per freed entry, lagging the pop by one cycle.
            r_co <= w_pop;
        end
    end

`ifdef CREDIT_CHECK_EN
    logic r_err_ovf;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_err_ovf <= 1'b0;
        end else if (in_valid && w_full) begin
            r_err_ovf <= 1'b1;
        end
    end

    assign err_ovf = r_err_ovf;
`else
    assign err_ovf = 1'b0;
`endif

    // Head is read straight from the storage registers; no path from datain.
    assign dataout   = r_mem[r_rd_ptr[AW-1:0]];
    assign out_valid = ~w_empty;
    assign occupancy = w_occupancy;
    assign co        = r_co;

endmodule

// File: tb/tb_credit_rx_buffer.sv
// tb/tb_credit_rx_buffer.sv - self-checking bench for credit_rx_buffer

module tb_credit_rx_buffer;

`ifdef CREDIT_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        clk;
    logic        RST;
    logic [19:0] datain;
    logic        in_valid;
    logic        co;
    logic [19:0] dataout;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  occupancy;
    logic        err_ovf;

    int n_vec;
    int n_err;

    credit_rx_buffer #(.WIDTH(20), .DEPTH(4), .AW(2)) dut (
        .clk       (clk),
        .RST       (RST),
        .datain    (datain),
        .in_valid  (in_valid),
        .co        (co),
        .dataout   (dataout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy),
        .err_ovf   (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [19:0] din;
        logic        rdy;
        logic [2:0]  occ;
        logic        vld;
        logic [19:0] dout;
        logic        co;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic iv, input logic [19:0] din, input logic rdy,
                       input logic [2:0] occ, input logic vld, input logic [19:0] dout,
                       input logic co_e, input logic err_e);
        vec_t v;
        v.iv = iv; v.din = din; v.rdy = rdy; v.occ = occ;
        v.vld = vld; v.dout = dout; v.co = co_e; v.err = err_e;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change #1 after the rising edge; outputs are compared at that same
    // point, i.e. they reflect the state produced by the edge just taken.
    task automatic step(input logic iv, input logic [19:0] din, input logic rdy);
        in_valid  = iv;
        datain    = din;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    int co_cnt;

    initial begin
        n_vec = 0;
        n_err = 0;
        in_valid  = 1'b0;
        datain    = '0;
        out_ready = 1'b0;
        RST       = 1'b0;

        // Fill, overflow (no pop), partial drain, concurrent push+pop, drain
        add(1, 20'h00001, 0, 3'd1, 1, 20'h00001, 0, 0);
        add(1, 20'h00002, 0, 3'd2, 1, 20'h00001, 0, 0);
        add(1, 20'h00003, 0, 3'd3, 1, 20'h00001, 0, 0);
        add(1, 20'h00004, 0, 3'd4, 1, 20'h00001, 0, 0);
        add(1, 20'h000FF, 0, 3'd4, 1, 20'h00001, 0, EXP_ERR);
        add(0, 20'h00000, 0, 3'd4, 1, 20'h00001, 0, EXP_ERR);
        add(0, 20'h00000, 1, 3'd3, 1, 20'h00002, 1, EXP_ERR);
        add(0, 20'h00000, 1, 3'd2, 1, 20'h00003, 1, EXP_ERR);
        add(1, 20'h0ABCD, 1, 3'd2, 1, 20'h00004, 1, EXP_ERR);
        add(0, 20'h00000, 1, 3'd1, 1, 20'h0ABCD, 1, EXP_ERR);
        add(0, 20'h00000, 1, 3'd0, 0, 20'h00000, 1, EXP_ERR);
        add(0, 20'h00000, 0, 3'd0, 0, 20'h00000, 0, EXP_ERR);
        // Refill across the pointer wrap, then push while full with a pop
        add(1, 20'h00011, 0, 3'd1, 1, 20'h00011, 0, EXP_ERR);
        add(1, 20'h00012, 0, 3'd2, 1, 20'h00011, 0, EXP_ERR);
        add(1, 20'h00013, 0, 3'd3, 1, 20'h00011, 0, EXP_ERR);
        add(1, 20'h00014, 0, 3'd4, 1, 20'h00011, 0, EXP_ERR);
        add(1, 20'h00055, 1, 3'd3, 1, 20'h00012, 1, EXP_ERR);
        add(0, 20'h00000, 1, 3'd2, 1, 20'h00013, 1, EXP_ERR);
        add(0, 20'h00000, 1, 3'd1, 1, 20'h00014, 1, EXP_ERR);
        add(0, 20'h00000, 1, 3'd0, 0, 20'h00000, 1, EXP_ERR);
        add(0, 20'h00000, 0, 3'd0, 0, 20'h00000, 0, EXP_ERR);

        // Reset state while held in reset with the clock running
        repeat (2) @(posedge clk);
        #1;
        check("rst occ",   32'(occupancy), 32'd0);
        check("rst valid", 32'(out_valid), 32'd0);
        check("rst co",    32'(co),        32'd0);
        check("rst err",   32'(err_ovf),   32'd0);
        RST = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].iv, tbl[i].din, tbl[i].rdy);
            check($sformatf("v%0d occ", i),   32'(occupancy), 32'(tbl[i].occ));
            check($sformatf("v%0d valid", i), 32'(out_valid), 32'(tbl[i].vld));
            if (tbl[i].vld)
                check($sformatf("v%0d data", i), 32'(dataout), 32'(tbl[i].dout));
            check($sformatf("v%0d co", i),    32'(co),        32'(tbl[i].co));
            check($sformatf("v%0d err", i),   32'(err_ovf),   32'(tbl[i].err));
        end

        // Stream 10 flits with out_ready held: 1-cycle latency, occupancy <= 1
        co_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 20'(k), 1'b1);
            if (co) co_cnt++;
            check($sformatf("stream%0d occ", k),   32'(occupancy), 32'd1);
            check($sformatf("stream%0d valid", k), 32'(out_valid), 32'd1);
            check($sformatf("stream%0d data", k),  32'(dataout),   32'(k));
        end
        step(1'b0, 20'h0, 1'b1);
        if (co) co_cnt++;
        check("stream tail occ", 32'(occupancy), 32'd0);
        step(1'b0, 20'h0, 1'b0);
        if (co) co_cnt++;
        check("stream co count", 32'(co_cnt), 32'd10);

        // Asynchronous reset with three flits held
        step(1'b1, 20'h00021, 1'b0);
        step(1'b1, 20'h00022, 1'b0);
        step(1'b1, 20'h00023, 1'b0);
        in_valid = 1'b0;
        check("pre-rst occ", 32'(occupancy), 32'd3);
        #2;
        RST = 1'b0;
        #1;
        check("async rst occ",   32'(occupancy), 32'd0);
        check("async rst valid", 32'(out_valid), 32'd0);
        check("async rst co",    32'(co),        32'd0);
        check("async rst err",   32'(err_ovf),   32'd0);
        @(posedge clk);
        #1;
        RST = 1'b1;
        co_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 20'h0, 1'b1);
            if (co) co_cnt++;
        end
        check("post-rst co count", 32'(co_cnt),    32'd0);
        check("post-rst occ",      32'(occupancy), 32'd0);
        check("post-rst valid",    32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
